// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex UART with shared frame format, fixed clock divider per bit
module uart_transceiver #(
  parameter int    DATA_BITS    = 8,
  parameter string PARITY_BIT   = "even",
  parameter int    STOP_BITS    = 2,
  parameter int    UART_CLK_DIV = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 transmit_start,
  output logic                 transmit_ready,
  output logic                 tx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_valid,
  output logic                 rx_error,
  input  logic                 rx
);
  localparam bit HAS_PAR = (PARITY_BIT != "none");
  localparam bit ODD_PAR = (PARITY_BIT == "odd");
  localparam int CW = $clog2(UART_CLK_DIV);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(UART_CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(UART_CLK_DIV / 2 - 1);
  localparam logic [IW-1:0] DATA_END = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_END = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic parity(input logic [DATA_BITS-1:0] d);
    return ODD_PAR ? ~^d : ^d;
  endfunction

  state_t                 tx_state, tx_state_n;
  logic [CW-1:0]          tx_cnt, tx_cnt_n;
  logic [IW-1:0]          tx_idx, tx_idx_n;
  logic [DATA_BITS-1:0]   tx_sh, tx_sh_n;
  logic                   tx_par, tx_par_n, tx_n, tx_tick;

  assign tx_tick        = (tx_cnt == BIT_END);
  assign transmit_ready = (tx_state == IDLE);

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_tick ? '0 : tx_cnt + 1'b1;
    tx_idx_n   = tx_idx;
    tx_sh_n    = tx_sh;
    tx_par_n   = tx_par;
    case (tx_state)
      IDLE: begin
        tx_cnt_n = '0;
        if (transmit_start) begin
          tx_state_n = START;
          tx_sh_n    = tx_data;
          tx_par_n   = parity(tx_data);
        end
      end
      START: if (tx_tick) begin
        tx_state_n = DATA;
        tx_idx_n   = '0;
      end
      DATA: if (tx_tick) begin
        tx_sh_n  = tx_sh >> 1;
        tx_idx_n = tx_idx + 1'b1;
        if (tx_idx == DATA_END) begin
          tx_state_n = HAS_PAR ? PARITY : STOP;
          tx_idx_n   = '0;
        end
      end
      PARITY: if (tx_tick) tx_state_n = STOP;
      STOP: if (tx_tick) begin
        tx_idx_n = tx_idx + 1'b1;
        if (tx_idx == STOP_END) tx_state_n = IDLE;
      end
      default: tx_state_n = IDLE;
    endcase
    // line level is registered from the next state so tx is glitch-free
    tx_n = (tx_state_n == START)  ? 1'b0 :
           (tx_state_n == DATA)   ? tx_sh_n[0] :
           (tx_state_n == PARITY) ? tx_par_n : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_sh    <= tx_sh_n;
      tx_par   <= tx_par_n;
      tx       <= tx_n;
    end
  end

  state_t                 rx_state, rx_state_n;
  logic [CW-1:0]          rx_cnt, rx_cnt_n;
  logic [IW-1:0]          rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0]   rx_sh, rx_sh_n, rx_data_n;
  logic                   rx_s1, rx_s2, rx_s3, rx_bad, rx_bad_n, valid_n, error_n, rx_tick;

  assign rx_tick = (rx_cnt == ((rx_state == START) ? HALF_END : BIT_END));

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_tick ? '0 : rx_cnt + 1'b1;
    rx_idx_n   = rx_idx;
    rx_sh_n    = rx_sh;
    rx_bad_n   = rx_bad;
    rx_data_n  = rx_data;
    valid_n    = 1'b0;
    error_n    = 1'b0;
    case (rx_state)
      IDLE: begin
        rx_cnt_n = '0;
        // a held-low line after a break never shows a 1->0 edge, so RX waits for idle
        if (rx_s3 && !rx_s2) begin
          rx_state_n = START;
          rx_bad_n   = 1'b0;
        end
      end
      START: if (rx_tick) begin
        rx_state_n = rx_s2 ? IDLE : DATA;
        rx_idx_n   = '0;
      end
      DATA: if (rx_tick) begin
        rx_sh_n  = (rx_sh >> 1) | (DATA_BITS'(rx_s2) << (DATA_BITS - 1));
        rx_idx_n = rx_idx + 1'b1;
        if (rx_idx == DATA_END) begin
          rx_state_n = HAS_PAR ? PARITY : STOP;
          rx_idx_n   = '0;
        end
      end
      PARITY: if (rx_tick) begin
        rx_bad_n   = (rx_s2 != parity(rx_sh));
        rx_state_n = STOP;
      end
      STOP: if (rx_tick) begin
        rx_bad_n = rx_bad | ~rx_s2;
        rx_idx_n = rx_idx + 1'b1;
        if (rx_idx == STOP_END) begin
          rx_state_n = IDLE;
          error_n    = rx_bad_n;
          valid_n    = ~rx_bad_n;
          rx_data_n  = rx_bad_n ? rx_data : rx_sh;
        end
      end
      default: rx_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1         <= 1'b1;
      rx_s2         <= 1'b1;
      rx_s3         <= 1'b1;
      rx_state      <= IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_sh         <= '0;
      rx_bad        <= 1'b0;
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      rx_error      <= 1'b0;
    end else begin
      rx_s1         <= rx;
      rx_s2         <= rx_s1;
      rx_s3         <= rx_s2;
      rx_state      <= rx_state_n;
      rx_cnt        <= rx_cnt_n;
      rx_idx        <= rx_idx_n;
      rx_sh         <= rx_sh_n;
      rx_bad        <= rx_bad_n;
      rx_data       <= rx_data_n;
      rx_data_valid <= valid_n;
      rx_error      <= error_n;
    end
  end
endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: directed table-driven bench for the 8E2 / DIV=20 transceiver
module tb_uart_transceiver;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       transmit_start = 1'b0;
  logic       transmit_ready, tx, rx_data_valid, rx_error;
  logic [7:0] rx_data;
  logic       loop = 1'b0;
  logic       rx_drv = 1'b1;
  logic       rx_line;
  int         total = 0, bad = 0;
  int         valid_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic [7:0] last_good;

  assign rx_line = loop ? tx : rx_drv;
  always #5 clk = ~clk;

  uart_transceiver dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .transmit_start(transmit_start),
    .transmit_ready(transmit_ready), .tx(tx), .rx_data(rx_data),
    .rx_data_valid(rx_data_valid), .rx_error(rx_error), .rx(rx_line)
  );

  typedef struct {
    logic [7:0]  data;
    logic [11:0] frame;
    bit          good;
  } vec_t;
  vec_t vecs[11];

  always @(negedge clk) if (!rst) begin
    if (rx_data_valid) valid_cnt++;
    if (rx_error) err_cnt++;
    if (rx_data_valid && rx_error) both_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [11:0] f, input bit check_bits, input bit disturb);
    int v0, e0, to;
    to = 0;
    while (!transmit_ready && to < 1000) begin
      @(negedge clk);
      to++;
    end
    chk("ready_wait", {31'b0, transmit_ready}, 32'd1);
    v0 = valid_cnt;
    e0 = err_cnt;
    tx_data = d;
    transmit_start = 1'b1;
    for (int n = 0; n < 240; n++) begin
      @(negedge clk);
      transmit_start = (disturb && n == 100);
      if (disturb && n == 100) tx_data = ~d;
      if (check_bits) begin
        chk($sformatf("tx_bit%0d", n / 20), {31'b0, tx}, {31'b0, f[n/20]});
        chk("ready_busy", {31'b0, transmit_ready}, 32'd0);
      end
    end
    @(negedge clk);
    transmit_start = 1'b0;
    if (check_bits) begin
      chk("ready_after", {31'b0, transmit_ready}, 32'd1);
      chk("tx_idle_after", {31'b0, tx}, 32'd1);
    end
    if (loop) begin
      chk("loop_valid", valid_cnt - v0, 32'd1);
      chk("loop_err", err_cnt - e0, 32'd0);
      chk("loop_data", {24'b0, rx_data}, {24'b0, d});
      last_good = d;
    end
  endtask

  task automatic rx_frame(input logic [11:0] f, input bit good, input logic [7:0] d);
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 12; i++) begin
      rx_drv = f[i];
      repeat (20) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (30) @(negedge clk);
    chk("rx_valid", valid_cnt - v0, {31'b0, good});
    chk("rx_err", err_cnt - e0, {31'b0, !good});
    chk("rx_data", {24'b0, rx_data}, {24'b0, good ? d : last_good});
    if (good) last_good = d;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0;
    vecs[0]  = '{8'hA5, 12'hD4A, 1'b1};
    vecs[1]  = '{8'h00, 12'hC00, 1'b1};
    vecs[2]  = '{8'hFF, 12'hDFE, 1'b1};
    vecs[3]  = '{8'h01, 12'hE02, 1'b1};
    vecs[4]  = '{8'h80, 12'hF00, 1'b1};
    vecs[5]  = '{8'h3C, 12'hC78, 1'b1};
    vecs[6]  = '{8'h5A, 12'hCB4, 1'b1};
    vecs[7]  = '{8'h07, 12'hE0E, 1'b1};
    vecs[8]  = '{8'h01, 12'hC02, 1'b0};
    vecs[9]  = '{8'h01, 12'hA02, 1'b0};
    vecs[10] = '{8'h01, 12'h602, 1'b0};
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_ready", {31'b0, transmit_ready}, 32'd1);
    chk("rst_rx_data", {24'b0, rx_data}, 32'd0);
    chk("rst_valid", {31'b0, rx_data_valid}, 32'd0);
    chk("rst_error", {31'b0, rx_error}, 32'd0);

    loop = 1'b1;
    for (int i = 0; i < 11; i++)
      if (vecs[i].good) send(vecs[i].data, vecs[i].frame, 1'b1, 1'b0);
    send(8'hA5, 12'hD4A, 1'b1, 1'b1);

    loop = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 11; i++) rx_frame(vecs[i].frame, vecs[i].good, vecs[i].data);

    v0 = valid_cnt;
    e0 = err_cnt;
    rx_drv = 1'b0;
    repeat (5) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_valid", valid_cnt - v0, 32'd0);
    chk("glitch_err", err_cnt - e0, 32'd0);
    rx_frame(12'hCB4, 1'b1, 8'h5A);

    v0 = valid_cnt;
    e0 = err_cnt;
    rx_drv = 1'b0;
    repeat (400) @(negedge clk);
    chk("break_err", err_cnt - e0, 32'd1);
    chk("break_valid", valid_cnt - v0, 32'd0);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    rx_frame(12'hE0E, 1'b1, 8'h07);

    loop = 1'b1;
    for (int b = 0; b < 255; b++) send(8'(b), 12'h000, 1'b0, 1'b0);

    loop = 1'b0;
    @(negedge clk);
    tx_data = 8'hA5;
    transmit_start = 1'b1;
    @(negedge clk);
    transmit_start = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx", {31'b0, tx}, 32'd1);
    chk("midrst_ready", {31'b0, transmit_ready}, 32'd1);
    chk("midrst_rx_data", {24'b0, rx_data}, 32'd0);
    chk("midrst_valid", {31'b0, rx_data_valid}, 32'd0);
    chk("midrst_error", {31'b0, rx_error}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    loop = 1'b1;
    send(8'hA5, 12'hD4A, 1'b1, 1'b0);

    chk("valid_and_error", both_cnt, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
